i_cache: RTL

Direct-mapped, read-only instruction cache between the instruction-fetch stage and the memory controller's fetch port. It answers fetch-stage PC requests in one cycle on a hit. On a miss it issues one word fetch to the memory controller, fills the line and returns the instruction. Memory-side arbitration (store > load > fetch) is the controller's job; this block only ever holds one fetch request outstanding.

---
 rtl/i_cache_pkg.sv | 16 +
 rtl/i_cache_if.sv | 23 ++
 rtl/i_cache_line_store.sv | 43 ++++
 rtl/i_cache.sv | 118 +++++++++++
 4 files changed

// File: rtl/i_cache_pkg.sv
// Shared types and defaults for the direct-mapped instruction cache.
package i_cache_pkg;

  localparam int unsigned ICACHE_INDEX_BITS = 6;

  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_MISS = 1'b1
  } icache_state_e;

  // Word address of a byte PC; the low two bits never select anything.
  function automatic logic [29:0] word_of(input logic [31:0] pc);
    return pc[31:2];
  endfunction

endpackage

// File: rtl/i_cache_if.sv
// Fetch-stage and memory-controller fetch-port signals of the instruction cache.
interface i_cache_if;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic        mem_fetch_enable;
  logic [31:0] mem_inst_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  modport slave (
    input  fetch_req, fetch_pc, flush, mem_valid, mem_data,
    output fetch_ready, fetch_valid, fetch_inst, mem_fetch_enable, mem_inst_addr
  );

  modport master (
    output fetch_req, fetch_pc, flush, mem_valid, mem_data,
    input  fetch_ready, fetch_valid, fetch_inst, mem_fetch_enable, mem_inst_addr
  );
endinterface

// File: rtl/i_cache_line_store.sv
// Valid/tag/data arrays: combinational read by index, synchronous write, async valid clear.
module i_cache_line_store #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_BITS-1:0]  rd_index,
  output logic                   rd_valid,
  output logic [29-INDEX_BITS:0] rd_tag,
  output logic [31:0]            rd_data,
  input  logic                   wr_en,
  input  logic [INDEX_BITS-1:0]  wr_index,
  input  logic [29-INDEX_BITS:0] wr_tag,
  input  logic [31:0]            wr_data
);
  localparam int unsigned Lines   = 1 << INDEX_BITS;
  localparam int unsigned TagBits = 30 - INDEX_BITS;

  logic [Lines-1:0]   valid_q;
  logic [TagBits-1:0] tag_q  [Lines];
  logic [31:0]        data_q [Lines];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/i_cache.sv
// Direct-mapped read-only instruction cache, one outstanding word fetch.
// Define ICACHE_STAT_EN to add the hit_count/miss_count statistics outputs.
module i_cache
  import i_cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  i_cache_if.slave    bus
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int unsigned TagBits = 30 - INDEX_BITS;

  icache_state_e      state_q;
  logic               drop_q;
  logic               fetch_valid_q;
  logic [31:0]        fetch_inst_q;
  logic               mem_en_q;
  logic [29:0]        req_word_q;

  logic               line_valid;
  logic [TagBits-1:0] line_tag;
  logic [31:0]        line_data;
  logic [29:0]        pc_word;
  logic               hit;
  logic               fill;

  assign pc_word = word_of(bus.fetch_pc);
  assign hit     = line_valid && (line_tag == pc_word[29:INDEX_BITS]);
  assign fill    = rdy && (state_q == ICACHE_MISS) && bus.mem_valid;

  i_cache_line_store #(
    .INDEX_BITS(INDEX_BITS)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_index (pc_word[INDEX_BITS-1:0]),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (fill),
    .wr_index (req_word_q[INDEX_BITS-1:0]),
    .wr_tag   (req_word_q[29:INDEX_BITS]),
    .wr_data  (bus.mem_data)
  );

`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ICACHE_IDLE;
      drop_q        <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_inst_q  <= '0;
      mem_en_q      <= 1'b0;
      req_word_q    <= '0;
`ifdef ICACHE_STAT_EN
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
`endif
    end else if (rdy) begin
      unique case (state_q)
        ICACHE_IDLE: begin
          fetch_valid_q <= 1'b0;
          if (!bus.flush && bus.fetch_req) begin
            if (hit) begin
              fetch_valid_q <= 1'b1;
              fetch_inst_q  <= line_data;
`ifdef ICACHE_STAT_EN
              hit_cnt_q     <= hit_cnt_q + 32'd1;
`endif
            end else begin
              req_word_q <= pc_word;
              mem_en_q   <= 1'b1;
              drop_q     <= 1'b0;
              state_q    <= ICACHE_MISS;
`ifdef ICACHE_STAT_EN
              miss_cnt_q <= miss_cnt_q + 32'd1;
`endif
            end
          end
        end
        ICACHE_MISS: begin
          fetch_valid_q <= 1'b0;
          if (bus.flush) begin
            drop_q <= 1'b1;
          end
          // The line is filled even when the delivery is dropped.
          if (bus.mem_valid) begin
            mem_en_q      <= 1'b0;
            fetch_valid_q <= ~(drop_q | bus.flush);
            fetch_inst_q  <= bus.mem_data;
            state_q       <= ICACHE_IDLE;
          end
        end
        default: state_q <= ICACHE_IDLE;
      endcase
    end
  end

  assign bus.fetch_ready      = (state_q == ICACHE_IDLE);
  assign bus.fetch_valid      = fetch_valid_q;
  assign bus.fetch_inst       = fetch_inst_q;
  assign bus.mem_fetch_enable = mem_en_q;
  assign bus.mem_inst_addr    = {req_word_q, 2'b00};

endmodule
